// File: rtl/ama_riscv_mem_arb.sv
// rtl/ama_riscv_mem_arb.sv - fetch/data arbiter for one single-ported memory; ARB_PERF_CNT_EN adds perf counters
module ama_riscv_mem_arb #(
  parameter int ADDR_W       = 14,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_req_valid,
  output logic              imem_req_ready,
  input  logic [ADDR_W-1:0] imem_req_addr,
  output logic              imem_rsp_valid,
  output logic [31:0]       imem_rsp_data,
  input  logic              dmem_req_valid,
  output logic              dmem_req_ready,
  input  logic [ADDR_W-1:0] dmem_req_addr,
  input  logic [31:0]       dmem_req_wdata,
  input  logic [3:0]        dmem_req_wmask,
  output logic              dmem_rsp_valid,
  output logic [31:0]       dmem_rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data
`ifdef ARB_PERF_CNT_EN
  ,
  input  logic              mmio_reset_cnt,
  output logic [31:0]       arb_cnt_imem_grant,
  output logic [31:0]       arb_cnt_dmem_grant,
  output logic [31:0]       arb_cnt_conflict,
  output logic [31:0]       arb_cnt_mem_busy
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IMEM, OWN_DMEM} owner_t;

  localparam logic [7:0] LP_STARVE_LIMIT = 8'(STARVE_LIMIT);

  state_t            r_state, w_state_nxt;
  owner_t            r_owner, w_owner_nxt;
  logic [7:0]        r_starve_cnt, w_starve_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wmask;
  logic              w_grant_imem;
  logic              w_grant_dmem;
  logic              w_rsp_fire;

  // Grant decision: data first unless fetch has lost too often; nothing is accepted during reset
  always_comb begin
    w_grant_imem = 1'b0;
    w_grant_dmem = 1'b0;
    if (!rst && (r_state == S_IDLE)) begin
      if (dmem_req_valid && (r_starve_cnt < LP_STARVE_LIMIT)) begin
        w_grant_dmem = 1'b1;
      end else if (imem_req_valid) begin
        w_grant_imem = 1'b1;
      end else if (dmem_req_valid) begin
        w_grant_dmem = 1'b1;
      end
    end
  end

  assign w_rsp_fire = !rst && (r_state == S_WAIT) && mem_rsp_valid;

  // Next state, owner and starvation counter
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_starve_nxt = r_starve_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_grant_imem) begin
          w_state_nxt = S_REQ;
          w_owner_nxt = OWN_IMEM;
        end else if (w_grant_dmem) begin
          w_state_nxt = S_REQ;
          w_owner_nxt = OWN_DMEM;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          w_state_nxt = S_IDLE;
          w_owner_nxt = OWN_NONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_owner_nxt = OWN_NONE;
      end
    endcase
    if (w_grant_imem) begin
      w_starve_nxt = 8'd0;
    end else if (w_grant_dmem && imem_req_valid && (r_starve_cnt != 8'hFF)) begin
      w_starve_nxt = r_starve_cnt + 8'd1;
    end
  end

  // State register and request payload capture in the accept cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_NONE;
      r_starve_cnt <= 8'd0;
      r_addr       <= '0;
      r_wdata      <= 32'd0;
      r_wmask      <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_starve_cnt <= w_starve_nxt;
      if (w_grant_imem) begin
        r_addr  <= imem_req_addr;
        r_wdata <= 32'd0;
        r_wmask <= 4'd0;
      end else if (w_grant_dmem) begin
        r_addr  <= dmem_req_addr;
        r_wdata <= dmem_req_wdata;
        r_wmask <= dmem_req_wmask;
      end
    end
  end

  assign imem_req_ready = w_grant_imem;
  assign dmem_req_ready = w_grant_dmem;
  assign mem_req_valid  = (r_state == S_REQ);
  assign mem_req_addr   = r_addr;
  assign mem_req_wdata  = r_wdata;
  assign mem_req_wmask  = r_wmask;

  // Response data is zeroed when not valid so idle outputs are quiet
  assign imem_rsp_valid = w_rsp_fire && (r_owner == OWN_IMEM);
  assign dmem_rsp_valid = w_rsp_fire && (r_owner == OWN_DMEM);
  assign imem_rsp_data  = imem_rsp_valid ? mem_rsp_data : 32'd0;
  assign dmem_rsp_data  = dmem_rsp_valid ? mem_rsp_data : 32'd0;

`ifdef SIM
  // A memory response is only legal while a transaction is outstanding
  a_rsp_only_in_wait : assert property (@(posedge clk) disable iff (rst)
    mem_rsp_valid |-> (r_state == S_WAIT));
`endif

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_cnt_imem_grant;
  logic [31:0] r_cnt_dmem_grant;
  logic [31:0] r_cnt_conflict;
  logic [31:0] r_cnt_mem_busy;

  function automatic logic [31:0] f_sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  // Saturating event counters; a clear beats a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || mmio_reset_cnt) begin
      r_cnt_imem_grant <= 32'd0;
      r_cnt_dmem_grant <= 32'd0;
      r_cnt_conflict   <= 32'd0;
      r_cnt_mem_busy   <= 32'd0;
    end else begin
      r_cnt_imem_grant <= f_sat_inc(r_cnt_imem_grant, w_grant_imem);
      r_cnt_dmem_grant <= f_sat_inc(r_cnt_dmem_grant, w_grant_dmem);
      r_cnt_conflict   <= f_sat_inc(r_cnt_conflict,
                                    (r_state == S_IDLE) && imem_req_valid && dmem_req_valid);
      r_cnt_mem_busy   <= f_sat_inc(r_cnt_mem_busy, r_state != S_IDLE);
    end
  end

  assign arb_cnt_imem_grant = r_cnt_imem_grant;
  assign arb_cnt_dmem_grant = r_cnt_dmem_grant;
  assign arb_cnt_conflict   = r_cnt_conflict;
  assign arb_cnt_mem_busy   = r_cnt_mem_busy;
`endif

endmodule

// File: tb/tb_ama_riscv_mem_arb.sv
// tb/tb_ama_riscv_mem_arb.sv - scoreboard bench for ama_riscv_mem_arb
module tb_ama_riscv_mem_arb;

  logic        clk;
  logic        rst;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [13:0] imem_req_addr;
  logic [31:0] imem_rsp_data;
  logic        dmem_req_valid, dmem_req_ready, dmem_rsp_valid;
  logic [13:0] dmem_req_addr;
  logic [31:0] dmem_req_wdata, dmem_rsp_data;
  logic [3:0]  dmem_req_wmask;
  logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [13:0] mem_req_addr;
  logic [31:0] mem_req_wdata, mem_rsp_data;
  logic [3:0]  mem_req_wmask;
`ifdef ARB_PERF_CNT_EN
  logic        mmio_reset_cnt;
  logic [31:0] arb_cnt_imem_grant, arb_cnt_dmem_grant, arb_cnt_conflict, arb_cnt_mem_busy;
`endif

  ama_riscv_mem_arb #(.ADDR_W(14), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata),
    .dmem_req_wmask(dmem_req_wmask), .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rsp_data(dmem_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_req_wmask(mem_req_wmask), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data)
`ifdef ARB_PERF_CNT_EN
    ,
    .mmio_reset_cnt(mmio_reset_cnt),
    .arb_cnt_imem_grant(arb_cnt_imem_grant), .arb_cnt_dmem_grant(arb_cnt_dmem_grant),
    .arb_cnt_conflict(arb_cnt_conflict), .arb_cnt_mem_busy(arb_cnt_mem_busy)
`endif
  );

  typedef struct {logic [13:0] addr; logic [31:0] wdata; logic [3:0] wmask;} req_t;
  typedef struct {logic chk; logic [31:0] data;} rsp_t;

  req_t iq[$], dq[$], mreq_exp[$];
  rsp_t iexp[$], dexp[$];
  bit   glog[$];
  int   n_cmp = 0, n_err = 0;
  int   cyc = 0, last_acc = -1, last_i_acc = 0, last_i_rsp = 0, last_mreq = 0;
  int   min_gap = 1000, max_gap = 0, n_irsp = 0, n_drsp = 0;
  logic rsp_hold = 0, inject_rsp = 0;
  logic prev_hold = 0;
  req_t prev_req;
  logic [31:0] mem [0:255];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Fetch requester
  initial begin
    req_t it;
    int   n;
    imem_req_valid = 0; imem_req_addr = 0;
    forever begin
      if (iq.size() == 0) begin @(posedge clk); #1; continue; end
      it = iq.pop_front();
      imem_req_valid = 1; imem_req_addr = it.addr;
      n = 0;
      do begin @(negedge clk); n++; end while (!imem_req_ready && n < 200);
      if (n >= 200) check("imem_accept_timeout", 32'(imem_req_ready), 1);
      @(posedge clk); #1;
      imem_req_valid = 0; imem_req_addr = 0;
    end
  end

  // Data requester
  initial begin
    req_t it;
    int   n;
    dmem_req_valid = 0; dmem_req_addr = 0; dmem_req_wdata = 0; dmem_req_wmask = 0;
    forever begin
      if (dq.size() == 0) begin @(posedge clk); #1; continue; end
      it = dq.pop_front();
      dmem_req_valid = 1; dmem_req_addr = it.addr;
      dmem_req_wdata = it.wdata; dmem_req_wmask = it.wmask;
      n = 0;
      do begin @(negedge clk); n++; end while (!dmem_req_ready && n < 200);
      if (n >= 200) check("dmem_accept_timeout", 32'(dmem_req_ready), 1);
      @(posedge clk); #1;
      dmem_req_valid = 0; dmem_req_addr = 0; dmem_req_wdata = 0; dmem_req_wmask = 0;
    end
  end

  // Memory model: accepts when ready, answers one cycle later
  initial begin
    logic        acc;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [3:0]  wm;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
    mem[8'h10] = 32'h0000_0013;
    mem_rsp_valid = 0; mem_rsp_data = 0;
    forever begin
      @(negedge clk);
      acc = mem_req_valid && mem_req_ready;
      a = mem_req_addr[7:0]; wd = mem_req_wdata; wm = mem_req_wmask;
      @(posedge clk); #1;
      if (acc) for (int b = 0; b < 4; b++) if (wm[b]) mem[a][8*b +: 8] = wd[8*b +: 8];
      mem_rsp_valid = (acc && !rsp_hold) || inject_rsp;
      mem_rsp_data  = (acc && wm == 4'd0) ? mem[a] : (inject_rsp ? 32'h5A5A_5A5A : 32'd0);
    end
  end

  // Monitor: grant log, request/response scoreboard, busy-time invariants
  initial begin
    req_t r;
    rsp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (imem_req_ready || dmem_req_ready) begin
        check("one_grant", 32'(imem_req_ready & dmem_req_ready), 0);
        glog.push_back(dmem_req_ready);
        if (last_acc >= 0) begin
          if (cyc - last_acc < min_gap) min_gap = cyc - last_acc;
          if (cyc - last_acc > max_gap) max_gap = cyc - last_acc;
        end
        last_acc = cyc;
        if (imem_req_ready) last_i_acc = cyc;
      end
      if (mem_req_valid) begin
        check("ready_while_busy", 32'(imem_req_ready | dmem_req_ready), 0);
        if (prev_hold) begin
          check("hold_addr", 32'(mem_req_addr), 32'(prev_req.addr));
          check("hold_wdata", mem_req_wdata, prev_req.wdata);
          check("hold_wmask", 32'(mem_req_wmask), 32'(prev_req.wmask));
        end
        if (mem_req_ready) begin
          last_mreq = cyc;
          check("mem_req_pending", 32'(mreq_exp.size() != 0), 1);
          if (mreq_exp.size() != 0) begin
            r = mreq_exp.pop_front();
            check("mem_req_addr", 32'(mem_req_addr), 32'(r.addr));
            check("mem_req_wdata", mem_req_wdata, r.wdata);
            check("mem_req_wmask", 32'(mem_req_wmask), 32'(r.wmask));
          end
        end
      end
      prev_hold = mem_req_valid && !mem_req_ready;
      prev_req.addr = mem_req_addr; prev_req.wdata = mem_req_wdata; prev_req.wmask = mem_req_wmask;
      if (imem_rsp_valid) begin
        n_irsp++; last_i_rsp = cyc;
        check("imem_rsp_pending", 32'(iexp.size() != 0), 1);
        if (iexp.size() != 0) begin
          e = iexp.pop_front();
          if (e.chk) check("imem_rsp_data", imem_rsp_data, e.data);
        end
      end
      if (dmem_rsp_valid) begin
        n_drsp++;
        check("dmem_rsp_pending", 32'(dexp.size() != 0), 1);
        if (dexp.size() != 0) begin
          e = dexp.pop_front();
          if (e.chk) check("dmem_rsp_data", dmem_rsp_data, e.data);
        end
      end
    end
  end

  task automatic wait_drain(input int lim);
    int n = 0;
    while ((iq.size() + dq.size() + iexp.size() + dexp.size() + mreq_exp.size()) != 0 && n < lim) begin
      @(negedge clk); n++;
    end
    check("drain", 32'(iq.size() + dq.size() + iexp.size() + dexp.size() + mreq_exp.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req_valid"}, 32'(mem_req_valid), 0);
    check({tag, "_imem_req_ready"}, 32'(imem_req_ready), 0);
    check({tag, "_dmem_req_ready"}, 32'(dmem_req_ready), 0);
    check({tag, "_imem_rsp_valid"}, 32'(imem_rsp_valid), 0);
    check({tag, "_dmem_rsp_valid"}, 32'(dmem_rsp_valid), 0);
    check({tag, "_mem_req_addr"}, 32'(mem_req_addr), 0);
    check({tag, "_mem_req_wdata"}, mem_req_wdata, 0);
    check({tag, "_mem_req_wmask"}, 32'(mem_req_wmask), 0);
    check({tag, "_imem_rsp_data"}, imem_rsp_data, 0);
    check({tag, "_dmem_rsp_data"}, dmem_rsp_data, 0);
  endtask

  task automatic push_d(input logic [13:0] a, input logic [31:0] wd, input logic [3:0] wm,
                        input logic chk, input logic [31:0] exp);
    dq.push_back('{a, wd, wm});
    mreq_exp.push_back('{a, wd, wm});
    dexp.push_back('{chk, exp});
  endtask

  task automatic push_i(input logic [13:0] a, input logic [31:0] exp);
    iq.push_back('{a, 32'd0, 4'd0});
    mreq_exp.push_back('{a, 32'd0, 4'd0});
    iexp.push_back('{1'b1, exp});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n, i0, d0;
    logic [9:0]  pat;
    rst = 1; mem_req_ready = 1;
`ifdef ARB_PERF_CNT_EN
    mmio_reset_cnt = 0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // Single fetch and its latency
    d0 = n_drsp;
    push_i(14'h010, 32'h0000_0013);
    wait_drain(100);
    check("fetch_memreq_lat", 32'(last_mreq - last_i_acc), 1);
    check("fetch_rsp_lat", 32'(last_i_rsp - last_i_acc), 2);
    check("fetch_no_dmem_rsp", 32'(n_drsp - d0), 0);

    // Partial store then readback through the memory
    i0 = n_irsp;
    push_d(14'h020, 32'hDEAD_BEEF, 4'hC, 1'b0, 32'd0);
    wait_drain(100);
    check("store_no_imem_rsp", 32'(n_irsp - i0), 0);
    check("store_one_dmem_rsp", 32'(n_drsp - d0), 1);
    push_d(14'h020, 32'd0, 4'h0, 1'b1, 32'hDEAD_0020);
    wait_drain(100);

    // Starvation: continuous conflict, 4 data grants then one fetch grant
    glog.delete(); last_acc = -1; min_gap = 1000; max_gap = 0;
    for (int k = 0; k < 4; k++) push_d(14'h080 + 14'(k), 32'd0, 4'h0, 1'b1, 32'hA000_0080 + k);
    push_i(14'h040, 32'hA000_0040);
    for (int k = 4; k < 8; k++) push_d(14'h080 + 14'(k), 32'd0, 4'h0, 1'b1, 32'hA000_0080 + k);
    push_i(14'h041, 32'hA000_0041);
    wait_drain(300);
    pat = 10'b0111101111;
    check("grant_count", 32'(glog.size()), 10);
    for (int k = 0; k < 10 && k < glog.size(); k++)
      check($sformatf("grant_%0d", k), 32'(glog[k]), 32'(pat[k]));
    check("min_accept_gap", 32'(min_gap), 3);
    check("max_accept_gap", 32'(max_gap), 3);

    // Back-pressure: memory stalls the request for several cycles
    mem_req_ready = 0;
    push_d(14'h050, 32'h1234_5678, 4'h0, 1'b1, 32'hA000_0050);
    push_i(14'h060, 32'hA000_0060);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("bp_valid_held", 32'(mem_req_valid), 1);
    check("bp_addr_held", 32'(mem_req_addr), 32'h050);
    @(posedge clk); #1;
    mem_req_ready = 1;
    wait_drain(100);

    // Reset while waiting for a response; the late response must be dropped
    rsp_hold = 1;
    i0 = n_irsp; d0 = n_drsp;
    iq.push_back('{14'h030, 32'd0, 4'd0});
    mreq_exp.push_back('{14'h030, 32'd0, 4'd0});
    n = 0;
    while (mreq_exp.size() != 0 && n < 50) begin @(negedge clk); n++; end
    check("rst_wait_reached", 32'(mreq_exp.size()), 0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check_all_zero("rst_wait");
    inject_rsp = 1;
    @(negedge clk);
    inject_rsp = 0;
    check("late_rsp_present", 32'(mem_rsp_valid), 1);
    check("late_rsp_imem", 32'(imem_rsp_valid), 0);
    check("late_rsp_dmem", 32'(dmem_rsp_valid), 0);
    repeat (3) @(negedge clk);
    rsp_hold = 0;
    check("rst_no_rsp", 32'((n_irsp - i0) + (n_drsp - d0)), 0);
    @(posedge clk); #1;

`ifdef ARB_PERF_CNT_EN
    mmio_reset_cnt = 1;
    @(posedge clk); #1;
    mmio_reset_cnt = 0;
    for (int k = 0; k < 3; k++) push_d(14'h090 + 14'(k), 32'd0, 4'h0, 1'b1, 32'hA000_0090 + k);
    push_i(14'h044, 32'hA000_0044);
    n = 0;
    do begin @(negedge clk); n++; end while (!imem_req_ready && n < 100);
    check("perf_conflict", arb_cnt_conflict, 3);
    check("perf_dmem_grant", arb_cnt_dmem_grant, 3);
    mmio_reset_cnt = 1;
    @(posedge clk); #1;
    mmio_reset_cnt = 0;
    check("perf_clr_imem", arb_cnt_imem_grant, 0);
    check("perf_clr_dmem", arb_cnt_dmem_grant, 0);
    check("perf_clr_conflict", arb_cnt_conflict, 0);
    check("perf_clr_busy", arb_cnt_mem_busy, 0);
    wait_drain(100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
